vga_color_stage: RTL

Parametrised colour-output stage for VGA_Control, placed between the pixel/line counters and the DAC pins. It decides whether the current Count_h/Count_v lies in the configured display window and drives RGB from one of four sources: pass-through Data, solid colour, colour bars or checkerboard. An optional border can be overlaid on the window edge. Output is delayed by a configurable pipeline so it can be aligned with the sync outputs.

---
 rtl/vga_color_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_color_stage.sv
// Colour-output stage: window/edge test, pattern source select, border overlay
// and a fixed-latency output pipeline feeding the DAC pins.
module vga_color_stage #(
  parameter int COLOR_WIDTH   = 4,
  parameter int DATA_WIDTH    = 3*COLOR_WIDTH,
  parameter int REZ_MAX_WIDTH = 11,
  parameter int PIPE_DEPTH    = 2,
  parameter int BAR_W         = 80,
  parameter int CHECK_SHIFT   = 5
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [DATA_WIDTH-1:0]    Data,
  input  logic [REZ_MAX_WIDTH-1:0] Count_h,
  input  logic [REZ_MAX_WIDTH-1:0] Count_v,
  input  logic [REZ_MAX_WIDTH-1:0] H_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0] H_right_margin,
  input  logic [REZ_MAX_WIDTH-1:0] V_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0] V_right_margin,
  input  logic [1:0]               Mode,
  input  logic [DATA_WIDTH-1:0]    Solid_color,
  input  logic                     Border_en,
  input  logic [DATA_WIDTH-1:0]    Border_color,
  output logic [COLOR_WIDTH-1:0]   Red,
  output logic [COLOR_WIDTH-1:0]   Green,
  output logic [COLOR_WIDTH-1:0]   Blue,
  output logic                     Active_out
);

  localparam int BPX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPX_W-1:0] BAR_LAST = BPX_W'(BAR_W - 1);

  logic [1:0]               mode_sh_q, mode_sh_d;
  logic                     border_sh_q, border_sh_d;
  logic [BPX_W-1:0]         bar_px_q, bar_px_d;
  logic [2:0]               bar_idx_q, bar_idx_d;
  logic                     frame_start, active, on_edge, left_col, chk;
  logic [REZ_MAX_WIDTH-1:0] dh, dv;
  logic [DATA_WIDTH-1:0]    bar_pix, pix_d;
  logic [DATA_WIDTH-1:0]    pix_q [PIPE_DEPTH];
  logic                     act_q [PIPE_DEPTH];

  // The frame-start pixel already uses the freshly loaded mode/border.
  assign frame_start = (Count_h == '0) && (Count_v == '0);
  assign mode_sh_d   = frame_start ? Mode : mode_sh_q;
  assign border_sh_d = frame_start ? Border_en : border_sh_q;

  assign active = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
                  (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
  assign left_col = (Count_h == H_left_margin);
  assign on_edge  = active && (left_col || (Count_h == H_right_margin) ||
                    (Count_v == V_left_margin) || (Count_v == V_right_margin));

  assign dh  = Count_h - H_left_margin;
  assign dv  = Count_v - V_left_margin;
  assign chk = 1'((dh ^ dv) >> CHECK_SHIFT);

  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (active) begin
      if (left_col) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  // Colour follows the updated index so every bar is exactly BAR_W pixels wide.
  assign bar_pix = {{COLOR_WIDTH{~bar_idx_d[0]}},
                    {COLOR_WIDTH{~bar_idx_d[2]}},
                    {COLOR_WIDTH{~bar_idx_d[1]}}};

  always_comb begin
    pix_d = '0;
    if (active) begin
      if (on_edge && border_sh_d) begin
        pix_d = Border_color;
      end else begin
        case (mode_sh_d)
          2'd0:    pix_d = Data;
          2'd1:    pix_d = Solid_color;
          2'd2:    pix_d = bar_pix;
          default: pix_d = chk ? '0 : {DATA_WIDTH{1'b1}};
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode_sh_q   <= '0;
      border_sh_q <= 1'b0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pix_q[i] <= '0;
        act_q[i] <= 1'b0;
      end
    end else begin
      mode_sh_q   <= mode_sh_d;
      border_sh_q <= border_sh_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      pix_q[0]    <= pix_d;
      act_q[0]    <= active;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pix_q[i] <= pix_q[i-1];
        act_q[i] <= act_q[i-1];
      end
    end
  end

  assign Red        = pix_q[PIPE_DEPTH-1][COLOR_WIDTH-1:0];
  assign Green      = pix_q[PIPE_DEPTH-1][2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign Blue       = pix_q[PIPE_DEPTH-1][DATA_WIDTH-1:2*COLOR_WIDTH];
  assign Active_out = act_q[PIPE_DEPTH-1];

endmodule
